// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional statistics counters are enabled by defining DM_ARB_STATS_EN.
package dm_pkg;

    localparam int DM_ADDR_W = 6;
    localparam int DM_DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } owner_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dm_rr_arb2.sv
// Two-input round-robin picker; the requester that did not win last time
// has priority when both are requesting. Purely combinational.
import dm_pkg::*;

module dm_rr_arb2 (
    input  logic   req0,
    input  logic   req1,
    input  owner_e last,
    output logic   gnt0,
    output logic   gnt1
);

    assign gnt0 = req0 & (~req1 | (last == REQ_DBG));
    assign gnt1 = req1 & (~req0 | (last == REQ_CORE));

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter/sequencer for the 64x32 data memory, 2-cycle access.
// Define DM_ARB_STATS_EN to add grant and contention counters.
import dm_pkg::*;

module dm_arbiter #(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
) (
    input  logic              clk_dm,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
`ifdef DM_ARB_STATS_EN
    output logic [15:0]       gcnt0,
    output logic [15:0]       gcnt1,
    output logic [15:0]       ccnt,
`endif
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            r_state;
    state_e            w_state_nxt;
    owner_e            r_last;
    owner_e            r_owner;
    owner_e            w_owner_nxt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              w_arb_gnt0;
    logic              w_arb_gnt1;
    logic              w_idle;
    logic              w_grant;

    dm_rr_arb2 u_rr (
        .req0 (req0),
        .req1 (req1),
        .last (r_last),
        .gnt0 (w_arb_gnt0),
        .gnt1 (w_arb_gnt1)
    );

    // Grants are only offered while the memory port is free.
    assign w_idle      = (r_state == IDLE);
    assign gnt0        = w_idle & w_arb_gnt0;
    assign gnt1        = w_idle & w_arb_gnt1;
    assign w_grant     = gnt0 | gnt1;
    assign w_owner_nxt = gnt1 ? REQ_DBG : REQ_CORE;

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:   if (w_grant) w_state_nxt = ACCESS;
            ACCESS: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= REQ_DBG;
            r_owner     <= REQ_CORE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if (w_grant) begin
                r_mem_addr  <= gnt1 ? addr1  : addr0;
                r_mem_we    <= gnt1 ? we1    : we0;
                r_mem_wdata <= gnt1 ? wdata1 : wdata0;
                r_owner     <= w_owner_nxt;
                r_last      <= w_owner_nxt;
            end
            if (r_state == ACCESS) begin
                r_mem_we <= 1'b0;
                if (r_owner == REQ_CORE) begin
                    r_rvalid0 <= 1'b1;
                    if (!r_mem_we) r_rdata0 <= mem_rdata;
                end else begin
                    r_rvalid1 <= 1'b1;
                    if (!r_mem_we) r_rdata1 <= mem_rdata;
                end
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;

`ifdef DM_ARB_STATS_EN
    logic [15:0] r_gcnt0;
    logic [15:0] r_gcnt1;
    logic [15:0] r_ccnt;

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            r_gcnt0 <= '0;
            r_gcnt1 <= '0;
            r_ccnt  <= '0;
        end else begin
            if (gnt0) r_gcnt0 <= sat_inc(r_gcnt0);
            if (gnt1) r_gcnt1 <= sat_inc(r_gcnt1);
            if (w_idle && req0 && req1) r_ccnt <= sat_inc(r_ccnt);
        end
    end

    assign gcnt0 = r_gcnt0;
    assign gcnt1 = r_gcnt1;
    assign ccnt  = r_ccnt;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed accesses push expected
// responses; a monitor pops and checks each rvalid pulse.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [5:0]  addr [2];
    logic [31:0] wdata [2];
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [64];
    logic        force_en = 1'b0;
    logic [31:0] force_val = '0;
`ifdef DM_ARB_STATS_EN
    logic [15:0] gcnt0, gcnt1, ccnt;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        int          p;
        logic [31:0] rd;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    dm_arbiter dut (
        .clk_dm    (clk),
        .rst_n     (rst_n),
        .req0      (req[0]),
        .we0       (we[0]),
        .addr0     (addr[0]),
        .wdata0    (wdata[0]),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req[1]),
        .we1       (we[1]),
        .addr1     (addr[1]),
        .wdata1    (wdata[1]),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
`ifdef DM_ARB_STATS_EN
        .gcnt0     (gcnt0),
        .gcnt1     (gcnt1),
        .ccnt      (ccnt),
`endif
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = force_en ? force_val : mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        int   pa;
        forever begin
            @(negedge clk);
            if (rvalid0 || rvalid1) begin
                pa = rvalid1 ? 1 : 0;
                if (rvalid0 && rvalid1) chk("rv_both", 32'd1, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("rv_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rv_port", pa, e.p);
                    chk("rv_cycle", cyc, e.cyc);
                    chk("rv_rdata", pa ? rdata1 : rdata0, e.rd);
                end
            end
        end
    end

    // One access; starts at the next rising edge, ends at the ACCESS negedge.
    task automatic access(input int p, input logic w, input logic [5:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          output int waits);
        bit got;
        @(posedge clk); #1;
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        got = 0;
        waits = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if ((p == 0) ? gnt0 : gnt1) begin
                got = 1;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        if (!got) begin
            chk("gnt_timeout", 32'd0, 32'd1);
            req[p] = 1'b0;
            return;
        end
        chk("gnt_other", (p == 0) ? gnt1 : gnt0, 32'd0);
        exp_q.push_back('{p: p, rd: exp_rd, cyc: cyc + 2});
        @(posedge clk); #1;
        req[p] = 1'b0;
        @(negedge clk);
        chk("acc_gnt0", gnt0, 32'd0);
        chk("acc_we", mem_we, w);
        chk("acc_addr", mem_addr, a);
        if (w) chk("acc_wdata", mem_wdata, d);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int w;
        int order [4];
        int ng;
`ifdef DM_ARB_STATS_EN
        logic [15:0] c0;
`endif
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rv", {rvalid1, rvalid0}, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rd0", rdata0, 0);
        chk("rst_rd1", rdata1, 0);
        #2 rst_n = 1'b1;

        access(0, 1'b1, 6'h05, 32'hDEADBEEF, 32'h0, w);
        chk("first_wait", w, 0);
        access(0, 1'b0, 6'h05, 32'h0, 32'hDEADBEEF, w);
        access(1, 1'b1, 6'h25, 32'h1, 32'h0, w);
        access(0, 1'b0, 6'h05, 32'h0, 32'hDEADBEEF, w);
        access(1, 1'b0, 6'h25, 32'h0, 32'h1, w);
        drain();

        // Both held: last=1, so 0,1,0,1 on cycles 0,2,4,6.
        order = '{0, 1, 0, 1};
        ng = 0;
        @(posedge clk); #1;
`ifdef DM_ARB_STATS_EN
        c0 = ccnt;
`endif
        req = 2'b11; we = 2'b00; addr[0] = 6'h05; addr[1] = 6'h25;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("both_gnt_any", gnt0 | gnt1, (k % 2 == 0) ? 1 : 0);
            if (gnt0 || gnt1) begin
                if (ng < 4) begin
                    chk("both_order", gnt1 ? 1 : 0, order[ng]);
                    exp_q.push_back('{p: order[ng],
                        rd: order[ng] == 1 ? 32'h1 : 32'hDEADBEEF,
                        cyc: cyc + 2});
                end
                ng++;
            end
            if (k < 7) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        req = 2'b00;
        chk("both_ngrants", ng, 4);
`ifdef DM_ARB_STATS_EN
        chk("ccnt_delta", ccnt - c0, 4);
`endif
        drain();

        // req0 held across ACCESS.
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 6'h05;
        @(negedge clk);
        chk("hold_gnt_c0", gnt0, 1);
        exp_q.push_back('{p: 0, rd: 32'hDEADBEEF, cyc: cyc + 2});
        @(negedge clk);
        chk("hold_gnt_c1", gnt0, 0);
        @(negedge clk);
        chk("hold_gnt_c2", gnt0, 1);
        exp_q.push_back('{p: 0, rd: 32'hDEADBEEF, cyc: cyc + 2});
        @(posedge clk); #1;
        req[0] = 1'b0;
        drain();

        // Reset during a write ACCESS.
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 6'h10; wdata[1] = 32'h77;
        @(negedge clk);
        chk("rstw_gnt1", gnt1, 1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        chk("rstw_we_pre", mem_we, 1);
        #2 rst_n = 1'b0;
        #1 chk("rstw_we_async", mem_we, 0);
        chk("rstw_rv_async", {rvalid1, rvalid0}, 0);
        @(negedge clk);
        chk("rstw_rv", {rvalid1, rvalid0}, 0);
        chk("rstw_rd1", rdata1, 0);
        #2 rst_n = 1'b1;
        access(0, 1'b0, 6'h05, 32'h0, 32'hDEADBEEF, w);
        chk("rstw_idle_wait", w, 0);
        drain();

        // Forced read data into requester 1, then held across others.
        force_en = 1'b1; force_val = 32'hA5A5A5A5;
        access(1, 1'b0, 6'h03, 32'h0, 32'hA5A5A5A5, w);
        chk("a5_rd1_before", rdata1, 32'h0);
        @(posedge clk); #1;
        force_en = 1'b0;
        access(0, 1'b1, 6'h04, 32'h1234, 32'hDEADBEEF, w);
        access(0, 1'b0, 6'h04, 32'h0, 32'h1234, w);
        drain();
        chk("a5_rd1_hold", rdata1, 32'hA5A5A5A5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-requester arbiter and sequencer in front of the 64-word x 32-bit data memory. Requester 0 is the core load/store unit; requester 1 is the debug/DMA loader. It grants one requester at a time, round-robin, and registers the winning address, data and write enable onto the memory port. It returns read data, or a write acknowledge, to the winner with fixed latency. It is the only driver of the memory's write-enable, address and write-data inputs.

Parameters:
ADDR_W, 6, memory word-address width; bit ADDR_W-1 selects the upper 32-word bank, passed through untouched.
DATA_W, 32, data width.

Ports:
clk_dm  in  1  memory clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0  in  1  requester 0 access request; held until gnt0.
we0  in  1  requester 0: 1=write, 0=read.
addr0  in  ADDR_W  requester 0 word address.
wdata0  in  DATA_W  requester 0 write data.
gnt0  out  1  combinational grant; req0 accepted this cycle.
rvalid0  out  1  one-cycle pulse: rdata0 valid (read) or write done.
rdata0  out  DATA_W  requester 0 read data, held until the next rvalid0.
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as the requester 0 set, for requester 1.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  combinational memory read data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Outputs gnt*, rvalid*, mem_we, mem_addr, mem_wdata, rdata0 and rdata1 are all 0. Priority pointer last=1, so requester 0 wins first.
- States: IDLE and ACCESS.
- IDLE, no request: stay in IDLE; mem_we=0.
- IDLE, one request: grant it.
- IDLE, both requesting: grant the requester that is not `last`.
- IDLE, on a grant: gnt asserts combinationally in the same cycle. At the clock edge, register addr, we and wdata into mem_addr, mem_we and mem_wdata, record the owner, set last=owner, and move to ACCESS.
- ACCESS: mem_* hold the registered values. At the edge, capture mem_rdata into rdata_owner, but only for reads; writes leave rdata unchanged. Then clear mem_we, go to IDLE, and pulse rvalid_owner for 1 cycle.
- No grants are issued while in ACCESS. Both gnt outputs are 0 there, even if requests are pending.
- Latency: gnt at cycle N, memory access at cycle N+1, rvalid/rdata at cycle N+2.
- Throughput: 1 access per 2 cycles.
- mem_addr and mem_wdata keep their last values in IDLE. mem_we is 1 only in ACCESS for a write.
- Starvation bound: a held request is granted within 4 cycles.
- A request that drops before its grant is ignored; there is no error.
- Reset mid-ACCESS aborts immediately: mem_we goes to 0 asynchronously, and no rvalid is produced.
- Write data is not masked or width-converted; the full DATA_W word is written.

Optional Feature:
- Macro DM_ARB_STATS_EN.
- Defined: adds outputs gcnt0, gcnt1 (16-bit, grants per requester) and ccnt (16-bit, IDLE cycles with both req0 and req1 high).
- The counters saturate at 0xFFFF and reset to 0.
- Not defined: these ports and counters are absent; the core behaviour is identical.

Decomposition:
- Shared package dm_pkg holds:
  - the state enum (IDLE=1'b0, ACCESS=1'b1);
  - DM_ADDR_W=6 and DM_DATA_W=32;
  - the owner encoding (REQ_CORE=0, REQ_DBG=1).
- One natural sub-module, dm_rr_arb2: a 2-input round-robin picker, with inputs req0, req1 and last, and outputs gnt0 and gnt1. It is purely combinational; `last` is held in the parent.

Test Plan:
- Reset, then req0 write addr=6'h05 wdata=32'hDEADBEEF:
  - gnt0 in cycle 0;
  - mem_we=1, mem_addr=5 in cycle 1;
  - rvalid0 in cycle 2.
  - A following read of addr 5 returns rdata0=32'hDEADBEEF at cycle +2.
- Upper bank: req1 write addr=6'h25 data=32'h1, then req0 read addr=6'h05 → 32'hDEADBEEF, and req1 read addr=6'h25 → 32'h1 (no aliasing).
- Both requesters held continuously: grants alternate 0,1,0,1 every 2 cycles. Four grants take 8 cycles; ccnt increments when DM_ARB_STATS_EN is defined.
- req0 held while in ACCESS: gnt0=0 during ACCESS, then gnt0=1 in the next IDLE cycle.
- rst_n low mid-ACCESS on a write: mem_we drops with no clock edge, rvalid stays 0, and state=IDLE after release.
- Read with mem_rdata=32'hA5A5A5A5: rdata1 updates only together with rvalid1, then holds while other accesses run.
